// File: rtl/peripheral_gpio_debounce_if.sv
// peripheral_gpio_debounce_if: pad/threshold inputs and debounced level/edge outputs; PERIPHERAL_GPIO_DEBOUNCE_BYPASS_EN adds bypass_i
interface peripheral_gpio_debounce_if #(
  parameter int PDATA_SIZE = 8,
  parameter int DEBOUNCE_WIDTH = 16
);
  logic [PDATA_SIZE-1:0] pad_i;
  logic [DEBOUNCE_WIDTH-1:0] debounce_cycles_i;
`ifdef PERIPHERAL_GPIO_DEBOUNCE_BYPASS_EN
  logic [PDATA_SIZE-1:0] bypass_i;
`endif
  logic [PDATA_SIZE-1:0] gpio_o;
  logic [PDATA_SIZE-1:0] rise_o;
  logic [PDATA_SIZE-1:0] fall_o;
`ifdef PERIPHERAL_GPIO_DEBOUNCE_BYPASS_EN
  modport master (output pad_i, debounce_cycles_i, bypass_i, input gpio_o, rise_o, fall_o);
  modport slave (input pad_i, debounce_cycles_i, bypass_i, output gpio_o, rise_o, fall_o);
`else
  modport master (output pad_i, debounce_cycles_i, input gpio_o, rise_o, fall_o);
  modport slave (input pad_i, debounce_cycles_i, output gpio_o, rise_o, fall_o);
`endif
endinterface

// File: rtl/peripheral_gpio_debounce.sv
// peripheral_gpio_debounce: per-bit pad synchroniser, glitch filter and edge pulser; PERIPHERAL_GPIO_DEBOUNCE_BYPASS_EN enables per-bit threshold bypass
module peripheral_gpio_debounce #(
  parameter int PDATA_SIZE = 8,
  parameter int SYNC_DEPTH = 3,
  parameter int DEBOUNCE_WIDTH = 16
) (
  input logic PCLK,
  input logic PRESETn,
  peripheral_gpio_debounce_if.slave bus
);
  for (genvar b = 0; b < PDATA_SIZE; b++) begin : g_bit
    logic [SYNC_DEPTH-1:0] sync_q;
    logic [DEBOUNCE_WIDTH-1:0] cnt_q;
    logic [DEBOUNCE_WIDTH:0] neff;
    logic stable_q, rise_q, fall_q, sync_last, accept;
    assign sync_last = sync_q[SYNC_DEPTH-1];
    // Effective threshold (zero acts as one) and acceptance once the mismatch has lasted that long
    always_comb begin
`ifdef PERIPHERAL_GPIO_DEBOUNCE_BYPASS_EN
      neff = (bus.bypass_i[b] || bus.debounce_cycles_i == '0) ? (DEBOUNCE_WIDTH+1)'(1) : {1'b0, bus.debounce_cycles_i};
`else
      neff = (bus.debounce_cycles_i == '0) ? (DEBOUNCE_WIDTH+1)'(1) : {1'b0, bus.debounce_cycles_i};
`endif
      accept = (sync_last != stable_q) && ({1'b0, cnt_q} + (DEBOUNCE_WIDTH+1)'(1) >= neff);
    end
    // Synchronise the pad, count consecutive mismatch cycles, commit the new level with a one-cycle edge pulse
    always_ff @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) begin
        sync_q <= '0;
        cnt_q <= '0;
        stable_q <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_DEPTH-2:0], bus.pad_i[b]};
        cnt_q <= (accept || sync_last == stable_q) ? '0 : cnt_q + DEBOUNCE_WIDTH'(1);
        stable_q <= accept ? sync_last : stable_q;
        rise_q <= accept && sync_last;
        fall_q <= accept && !sync_last;
      end
    assign bus.gpio_o[b] = stable_q;
    assign bus.rise_o[b] = rise_q;
    assign bus.fall_o[b] = fall_q;
  end
endmodule

// File: tb/tb_peripheral_gpio_debounce.sv
// tb_peripheral_gpio_debounce: scoreboard bench for the pad debouncer
module tb_peripheral_gpio_debounce;
  typedef struct {
    int k;
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] f;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  exp_t sb[$];
  exp_t e;
  peripheral_gpio_debounce_if #(.PDATA_SIZE(8), .DEBOUNCE_WIDTH(16)) bus ();
  peripheral_gpio_debounce #(.PDATA_SIZE(8), .SYNC_DEPTH(3), .DEBOUNCE_WIDTH(16)) dut (
    .PCLK(clk),
    .PRESETn(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic init(input logic [7:0] p, input logic [15:0] n);
    rst_n = 1'b0;
    bus.pad_i = p;
    bus.debounce_cycles_i = 16'd1;
`ifdef PERIPHERAL_GPIO_DEBOUNCE_BYPASS_EN
    bus.bypass_i = 8'h00;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    bus.debounce_cycles_i = n;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.pad_i = 8'hFF;
    bus.debounce_cycles_i = 16'd4;
`ifdef PERIPHERAL_GPIO_DEBOUNCE_BYPASS_EN
    bus.bypass_i = 8'h00;
`endif
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({bus.gpio_o, bus.rise_o, bus.fall_o} !== 24'h0) begin
      fails++;
      $display("FAIL reset_hold got %h/%h/%h exp 00/00/00", bus.gpio_o, bus.rise_o, bus.fall_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) sb.push_back(exp_t'{k, (k >= 7) ? 8'hFF : 8'h00, (k == 7) ? 8'hFF : 8'h00, 8'h00});
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (sb.size() != 0 && sb[0].k == k) begin
        e = sb.pop_front();
        tests++;
        if ({bus.gpio_o, bus.rise_o, bus.fall_o} !== {e.g, e.r, e.f}) begin
          fails++;
          $display("FAIL reset_release k=%0d got %h/%h/%h exp %h/%h/%h", k, bus.gpio_o, bus.rise_o, bus.fall_o, e.g, e.r, e.f);
        end
      end
    end
  endtask

  task automatic test_clean_edge;
    init(8'h00, 16'd4);
    for (int p = 0; p < 2; p++) begin
      bus.pad_i = (p == 0) ? 8'h01 : 8'h00;
      for (int k = 1; k <= 10; k++)
        sb.push_back(exp_t'{k, ((k >= 7) ^ (p == 1)) ? 8'h01 : 8'h00, (k == 7 && p == 0) ? 8'h01 : 8'h00, (k == 7 && p == 1) ? 8'h01 : 8'h00});
      for (int k = 1; k <= 10; k++) begin
        @(posedge clk); #1;
        if (sb.size() != 0 && sb[0].k == k) begin
          e = sb.pop_front();
          tests++;
          if ({bus.gpio_o, bus.rise_o, bus.fall_o} !== {e.g, e.r, e.f}) begin
            fails++;
            $display("FAIL clean_edge p=%0d k=%0d got %h/%h/%h exp %h/%h/%h", p, k, bus.gpio_o, bus.rise_o, bus.fall_o, e.g, e.r, e.f);
          end
        end
      end
    end
  endtask

  task automatic test_glitch;
    init(8'h00, 16'd4);
    for (int h = 3; h <= 4; h++) begin
      bus.pad_i = 8'h04;
      for (int k = 1; k <= 12; k++)
        sb.push_back(exp_t'{k, (h == 4 && k >= 7 && k <= 10) ? 8'h04 : 8'h00, (h == 4 && k == 7) ? 8'h04 : 8'h00, (h == 4 && k == 11) ? 8'h04 : 8'h00});
      for (int k = 1; k <= 12; k++) begin
        @(posedge clk); #1;
        if (sb.size() != 0 && sb[0].k == k) begin
          e = sb.pop_front();
          tests++;
          if ({bus.gpio_o, bus.rise_o, bus.fall_o} !== {e.g, e.r, e.f}) begin
            fails++;
            $display("FAIL glitch h=%0d k=%0d got %h/%h/%h exp %h/%h/%h", h, k, bus.gpio_o, bus.rise_o, bus.fall_o, e.g, e.r, e.f);
          end
        end
        if (k == h) bus.pad_i = 8'h00;
      end
    end
  endtask

  task automatic test_boundary;
    init(8'h00, 16'd0);
    for (int n = 0; n < 2; n++) begin
      bus.debounce_cycles_i = 16'(n);
      bus.pad_i = (n == 0) ? 8'h08 : 8'h00;
      for (int k = 1; k <= 5; k++)
        sb.push_back(exp_t'{k, ((k >= 4) ^ (n == 1)) ? 8'h08 : 8'h00, (k == 4 && n == 0) ? 8'h08 : 8'h00, (k == 4 && n == 1) ? 8'h08 : 8'h00});
      for (int k = 1; k <= 5; k++) begin
        @(posedge clk); #1;
        if (sb.size() != 0 && sb[0].k == k) begin
          e = sb.pop_front();
          tests++;
          if ({bus.gpio_o, bus.rise_o, bus.fall_o} !== {e.g, e.r, e.f}) begin
            fails++;
            $display("FAIL boundary n=%0d k=%0d got %h/%h/%h exp %h/%h/%h", n, k, bus.gpio_o, bus.rise_o, bus.fall_o, e.g, e.r, e.f);
          end
        end
      end
    end
    bus.debounce_cycles_i = 16'hFFFF;
    bus.pad_i = 8'h10;
    sb.push_back(exp_t'{65537, 8'h00, 8'h00, 8'h00});
    sb.push_back(exp_t'{65538, 8'h10, 8'h10, 8'h00});
    sb.push_back(exp_t'{65540, 8'h10, 8'h00, 8'h00});
    for (int k = 1; k <= 65540; k++) begin
      @(posedge clk); #1;
      if (sb.size() != 0 && sb[0].k == k) begin
        e = sb.pop_front();
        tests++;
        if ({bus.gpio_o, bus.rise_o, bus.fall_o} !== {e.g, e.r, e.f}) begin
          fails++;
          $display("FAIL max_threshold k=%0d got %h/%h/%h exp %h/%h/%h", k, bus.gpio_o, bus.rise_o, bus.fall_o, e.g, e.r, e.f);
        end
      end
    end
  endtask

  task automatic test_threshold_drop;
    init(8'h00, 16'd100);
    bus.pad_i = 8'h20;
    sb.push_back(exp_t'{53, 8'h00, 8'h00, 8'h00});
    sb.push_back(exp_t'{54, 8'h20, 8'h20, 8'h00});
    sb.push_back(exp_t'{55, 8'h20, 8'h00, 8'h00});
    for (int k = 1; k <= 55; k++) begin
      @(posedge clk); #1;
      if (sb.size() != 0 && sb[0].k == k) begin
        e = sb.pop_front();
        tests++;
        if ({bus.gpio_o, bus.rise_o, bus.fall_o} !== {e.g, e.r, e.f}) begin
          fails++;
          $display("FAIL threshold_drop k=%0d got %h/%h/%h exp %h/%h/%h", k, bus.gpio_o, bus.rise_o, bus.fall_o, e.g, e.r, e.f);
        end
      end
      if (k == 53) bus.debounce_cycles_i = 16'd10;
    end
  endtask

  task automatic test_async_reset;
    init(8'h30, 16'd4);
    bus.pad_i = 8'h60;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.gpio_o, bus.rise_o, bus.fall_o} !== 24'h0) begin
      fails++;
      $display("FAIL async_reset got %h/%h/%h exp 00/00/00", bus.gpio_o, bus.rise_o, bus.fall_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) sb.push_back(exp_t'{k, (k >= 7) ? 8'h60 : 8'h00, (k == 7) ? 8'h60 : 8'h00, 8'h00});
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (sb.size() != 0 && sb[0].k == k) begin
        e = sb.pop_front();
        tests++;
        if ({bus.gpio_o, bus.rise_o, bus.fall_o} !== {e.g, e.r, e.f}) begin
          fails++;
          $display("FAIL async_restart k=%0d got %h/%h/%h exp %h/%h/%h", k, bus.gpio_o, bus.rise_o, bus.fall_o, e.g, e.r, e.f);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    init(8'h0F, 16'd2);
    bus.pad_i = 8'hF0;
    for (int k = 1; k <= 7; k++) sb.push_back(exp_t'{k, (k >= 5) ? 8'hF0 : 8'h0F, (k == 5) ? 8'hF0 : 8'h00, (k == 5) ? 8'h0F : 8'h00});
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (sb.size() != 0 && sb[0].k == k) begin
        e = sb.pop_front();
        tests++;
        if ({bus.gpio_o, bus.rise_o, bus.fall_o} !== {e.g, e.r, e.f}) begin
          fails++;
          $display("FAIL multi_bit k=%0d got %h/%h/%h exp %h/%h/%h", k, bus.gpio_o, bus.rise_o, bus.fall_o, e.g, e.r, e.f);
        end
      end
    end
  endtask

`ifdef PERIPHERAL_GPIO_DEBOUNCE_BYPASS_EN
  task automatic test_bypass;
    init(8'h00, 16'd8);
    bus.bypass_i = 8'h01;
    bus.pad_i = 8'h03;
    for (int k = 1; k <= 12; k++)
      sb.push_back(exp_t'{k, {6'b0, k >= 11, k >= 4}, {6'b0, k == 11, k == 4}, 8'h00});
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (sb.size() != 0 && sb[0].k == k) begin
        e = sb.pop_front();
        tests++;
        if ({bus.gpio_o, bus.rise_o, bus.fall_o} !== {e.g, e.r, e.f}) begin
          fails++;
          $display("FAIL bypass k=%0d got %h/%h/%h exp %h/%h/%h", k, bus.gpio_o, bus.rise_o, bus.fall_o, e.g, e.r, e.f);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_edge();
    test_glitch();
    test_boundary();
    test_threshold_drop();
    test_async_reset();
    test_back_to_back();
`ifdef PERIPHERAL_GPIO_DEBOUNCE_BYPASS_EN
    test_bypass();
`endif
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d entries exp 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
